// File: rtl/instr_decode_stage_if.sv
// Upstream/downstream handshake and decoded-field bundle for instr_decode_stage.
// The decode stage connects through the slave modport; the instruction source/sink uses master.
interface instr_decode_stage_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [6:0]      out_opcode;
    logic [2:0]      out_func3;
    logic [6:0]      out_func7;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;
    logic [PC_W-1:0] out_pc;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_opcode, out_func3, out_func7,
               out_rd, out_rs1, out_rs2, out_imm, out_fmt, out_illegal, out_pc
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_opcode, out_func3, out_func7,
               out_rd, out_rs1, out_rs2, out_imm, out_fmt, out_illegal, out_pc
    );
endinterface

// File: rtl/instr_decode_stage.sv
// RV32 instruction decode stage: decodes on entry, then holds results in a
// two-entry skid buffer (main + skid) so in_ready can be a plain register.
module instr_decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_decode_stage_if.slave  bus
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
        logic [PC_W-1:0] pc;
    } dec_t;

    // Field slices are raw; the immediate is built at 32 bits and then sign-extended to XLEN.
    function automatic dec_t decode(input logic [31:0] instr, input logic [PC_W-1:0] pc);
        dec_t        d;
        logic [31:0] imm32;
        d         = '0;
        imm32     = 32'd0;
        d.opcode  = instr[6:0];
        d.func3   = instr[14:12];
        d.func7   = instr[31:25];
        d.rd      = instr[11:7];
        d.rs1     = instr[19:15];
        d.rs2     = instr[24:20];
        d.pc      = pc;
        d.fmt     = FMT_ILL;
        d.illegal = 1'b1;
        if (instr[1:0] == 2'b11) begin
            d.illegal = 1'b0;
            case (instr[6:0])
                7'b0110011: begin
                    d.fmt = FMT_R;
                end
                7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                    d.fmt = FMT_I;
                    imm32 = {{20{instr[31]}}, instr[31:20]};
                end
                7'b0100011: begin
                    d.fmt = FMT_S;
                    imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                end
                7'b1100011: begin
                    d.fmt = FMT_B;
                    imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                end
                7'b0110111, 7'b0010111: begin
                    d.fmt = FMT_U;
                    imm32 = {instr[31:12], 12'd0};
                end
                7'b1101111: begin
                    d.fmt = FMT_J;
                    imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                end
                default: begin
                    d.fmt     = FMT_ILL;
                    d.illegal = 1'b1;
                end
            endcase
        end else begin
            d.fmt     = FMT_ILL;
            d.illegal = 1'b1;
        end
        d.imm = XLEN'(signed'(imm32));
        return d;
    endfunction

    state_t state_q, state_d;
    dec_t   main_q,  main_d;
    dec_t   skid_q,  skid_d;
    logic   ready_q, ready_d;
    logic   valid_q, valid_d;

    dec_t   dec_s;
    logic   accept_s;
    logic   xfer_s;

    assign dec_s    = decode(bus.in_instr, bus.in_pc);
    assign accept_s = bus.in_valid && ready_q;
    assign xfer_s   = valid_q && bus.out_ready;

    // State and storage registers; reset overrides flush and handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    // Next-state and buffer steering; the skid entry only fills when main is stalled.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush) begin
            state_d = S_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept_s) begin
                        main_d  = dec_s;
                        state_d = S_ONE;
                    end else begin
                        state_d = S_EMPTY;
                    end
                end
                S_ONE: begin
                    if (accept_s && xfer_s) begin
                        main_d  = dec_s;
                        state_d = S_ONE;
                    end else if (accept_s) begin
                        skid_d  = dec_s;
                        state_d = S_TWO;
                    end else if (xfer_s) begin
                        main_d  = '0;
                        state_d = S_EMPTY;
                    end else begin
                        state_d = S_ONE;
                    end
                end
                S_TWO: begin
                    if (xfer_s) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = S_ONE;
                    end else begin
                        state_d = S_TWO;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
        valid_d = (state_d != S_EMPTY);
        ready_d = (state_d != S_TWO);
    end

    assign bus.in_ready    = ready_q;
    assign bus.out_valid   = valid_q;
    assign bus.out_opcode  = main_q.opcode;
    assign bus.out_func3   = main_q.func3;
    assign bus.out_func7   = main_q.func7;
    assign bus.out_rd      = main_q.rd;
    assign bus.out_rs1     = main_q.rs1;
    assign bus.out_rs2     = main_q.rs2;
    assign bus.out_imm     = main_q.imm;
    assign bus.out_fmt     = main_q.fmt;
    assign bus.out_illegal = main_q.illegal;
    assign bus.out_pc      = main_q.pc;

endmodule
